// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_pkg : funct3 access encodings and LSU state enum.       Rev 1.0      |
// +--------------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   // Reserved encodings fall through to a word access.
   function automatic lsu_size_e access_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: access_size = SZ_BYTE;
         F3_H, F3_HU: access_size = SZ_HALF;
         F3_W:        access_size = SZ_WORD;
         default:     access_size = SZ_WORD;
      endcase
   endfunction

   function automatic logic is_unsigned(input logic [2:0] funct3);
      is_unsigned = (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_load_align : lane select and sign/zero extension of load data. R1.0  |
// +--------------------------------------------------------------------------+
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        uns;

   always_comb begin
      byte_sel = rdata[8*addr_lo +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      uns      = is_unsigned(funct3);
      case (access_size(funct3))
         SZ_BYTE: data = {{24{byte_sel[7] & ~uns}}, byte_sel};
         SZ_HALF: data = {{16{half_sel[15] & ~uns}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit : single-outstanding LSU between EX and a req/rsp bus.   |
// | Optional: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses. R1.0 |
// +--------------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_rs2_data,
   input  logic [2:0]  ex_funct3,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_wstrb,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        lsu_stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_trap,
   output logic [31:0] misalign_addr
);

   lsu_state_e  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [4:0]  rd_q, rd_d;
   logic        reg_write_q, reg_write_d;
   logic        we_q, we_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [31:0] load_data;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        mem_op;

`ifdef LSU_MISALIGN_TRAP_EN
   logic        trap_q, trap_d;
   logic [31:0] trap_addr_q, trap_addr_d;
   logic        misalign_hit;
`endif

   lsu_load_align u_load_align (
      .rdata   (mem_rsp_rdata),
      .addr_lo (addr_q[1:0]),
      .funct3  (funct3_q),
      .data    (load_data)
   );

   // Store lanes are formed at capture so the bus fields stay constant in REQ.
   always_comb begin
      mem_op = ex_mem_read | ex_mem_write;
      case (access_size(ex_funct3))
         SZ_BYTE: begin
            st_wstrb = 4'b0001 << ex_alu_result[1:0];
            st_wdata = {4{ex_rs2_data[7:0]}};
         end
         SZ_HALF: begin
            st_wstrb = 4'b0011 << {ex_alu_result[1], 1'b0};
            st_wdata = {2{ex_rs2_data[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = ex_rs2_data;
         end
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      case (access_size(ex_funct3))
         SZ_HALF: misalign_hit = ex_alu_result[0];
         SZ_WORD: misalign_hit = (ex_alu_result[1:0] != 2'b00);
         default: misalign_hit = 1'b0;
      endcase
`endif
   end

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      funct3_d       = funct3_q;
      rd_d           = rd_q;
      reg_write_d    = reg_write_q;
      we_d           = we_q;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = wb_reg_write_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_d         = 1'b0;
      trap_addr_d    = trap_addr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if (!mem_op) begin
                  wb_valid_d     = 1'b1;
                  wb_data_d      = ex_alu_result;
                  wb_rd_d        = ex_rd;
                  wb_reg_write_d = ex_reg_write;
               end
`ifdef LSU_MISALIGN_TRAP_EN
               else if (misalign_hit) begin
                  wb_valid_d     = 1'b1;
                  wb_reg_write_d = 1'b0;
                  wb_rd_d        = ex_rd;
                  trap_d         = 1'b1;
                  trap_addr_d    = ex_alu_result;
               end
`endif
               else begin
                  addr_d      = ex_alu_result;
                  wdata_d     = st_wdata;
                  wstrb_d     = st_wstrb;
                  funct3_d    = ex_funct3;
                  rd_d        = ex_rd;
                  reg_write_d = ex_reg_write;
                  we_d        = ex_mem_write;
                  state_d     = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               if (we_q) begin
                  state_d        = ST_IDLE;
                  wb_valid_d     = 1'b1;
                  wb_reg_write_d = 1'b0;
                  wb_rd_d        = rd_q;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               state_d        = ST_IDLE;
               wb_valid_d     = 1'b1;
               wb_reg_write_d = reg_write_q;
               wb_rd_d        = rd_q;
               wb_data_d      = load_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         funct3_q       <= '0;
         rd_q           <= '0;
         reg_write_q    <= 1'b0;
         we_q           <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         trap_q         <= 1'b0;
         trap_addr_q    <= '0;
`endif
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         funct3_q       <= funct3_d;
         rd_q           <= rd_d;
         reg_write_q    <= reg_write_d;
         we_q           <= we_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
         trap_q         <= trap_d;
         trap_addr_q    <= trap_addr_d;
`endif
      end
   end

   assign lsu_stall     = (state_q != ST_IDLE);
   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_addr  = {addr_q[31:2], 2'b00};
   assign mem_req_we    = we_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;
   assign wb_valid      = wb_valid_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign wb_rd         = wb_rd_q;
   assign wb_data       = wb_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_trap = trap_q;
   assign misalign_addr = trap_addr_q;
`else
   assign misalign_trap = 1'b0;
   assign misalign_addr = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_load_store_unit : directed + random checks against a lane model. R1.0 |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_rs2_data;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic [4:0]  ex_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        lsu_stall;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misalign_trap;
   logic [31:0] misalign_addr;

   int checks = 0;
   int errors = 0;

   load_store_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_alu_result (ex_alu_result),
      .ex_rs2_data   (ex_rs2_data),
      .ex_funct3     (ex_funct3),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_reg_write  (ex_reg_write),
      .ex_rd         (ex_rd),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_we    (mem_req_we),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata),
      .lsu_stall     (lsu_stall),
      .wb_valid      (wb_valid),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .misalign_trap (misalign_trap),
      .misalign_addr (misalign_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic rbit();
      logic [31:0] r;
      r = $urandom;
      return r[0];
   endfunction

   // Reference model: access size in bytes, lanes and extension by arithmetic.
   function automatic int m_size(input logic [2:0] f3);
      int s;
      if (f3[1:0] == 2'b00) s = 1;
      else if (f3[1:0] == 2'b01) s = 2;
      else s = 4;
      return s;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [2:0] f3);
      int s;
      int off;
      logic [31:0] st;
      s   = m_size(f3);
      off = (s == 1) ? int'(a % 4) : ((s == 2) ? ((a % 4 >= 2) ? 2 : 0) : 0);
      st  = (s == 1) ? 32'd1 : ((s == 2) ? 32'd3 : 32'd15);
      st  = st << off;
      return st[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic [2:0] f3);
      int s;
      s = m_size(f3);
      if (s == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
      if (s == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
      return rs2;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] a,
                                          input logic [2:0] f3);
      int s;
      int off;
      logic [31:0] v;
      logic [31:0] mask;
      s   = m_size(f3);
      off = (s == 1) ? int'(a % 4) : ((s == 2) ? ((a % 4 >= 2) ? 2 : 0) : 0);
      v   = rdata >> (8 * off);
      if (s == 4) return v;
      mask = (s == 1) ? 32'hFF : 32'hFFFF;
      v    = v & mask;
      if (f3[2] == 1'b0 && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic m_misaligned(input logic [31:0] a, input logic [2:0] f3);
      int s;
      s = m_size(f3);
      return (s == 2 && (a % 2) != 0) || (s == 4 && (a % 4) != 0);
   endfunction

   task automatic garbage_ex();
      ex_valid      = 1'b1;
      ex_alu_result = $urandom;
      ex_rs2_data   = $urandom;
      ex_rd         = 5'($urandom);
      ex_funct3     = 3'($urandom);
      ex_mem_read   = rbit();
      ex_mem_write  = rbit();
      ex_reg_write  = rbit();
   endtask

   task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdata);
      logic [31:0] waddr;
      waddr = alu & 32'hFFFF_FFFC;
      chk1("stall_before_issue", lsu_stall, 1'b0);
      ex_valid      = 1'b1;
      ex_alu_result = alu;
      ex_rs2_data   = rs2;
      ex_funct3     = f3;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_mem_read   = mr;
      ex_mem_write  = mw;
      mem_req_ready = rbit();
      mem_rsp_valid = rbit();
      mem_rsp_rdata = $urandom;
      tick();
      if (!(mr || mw)) begin
         ex_valid = 1'b0;
         chk1("alu_wb_valid", wb_valid, 1'b1);
         chk("alu_wb_data", wb_data, alu);
         chk("alu_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
         chk1("alu_wb_reg_write", wb_reg_write, rw);
         chk1("alu_stall", lsu_stall, 1'b0);
         chk1("alu_req_valid", mem_req_valid, 1'b0);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      else if (m_misaligned(alu, f3)) begin
         ex_valid = 1'b0;
         chk1("trap_pulse", misalign_trap, 1'b1);
         chk("trap_addr", misalign_addr, alu);
         chk1("trap_wb_valid", wb_valid, 1'b1);
         chk1("trap_wb_reg_write", wb_reg_write, 1'b0);
         chk1("trap_req_valid", mem_req_valid, 1'b0);
         chk1("trap_stall", lsu_stall, 1'b0);
      end
`endif
      else begin
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         chk1("req_stall", lsu_stall, 1'b1);
         chk1("req_wb_valid", wb_valid, 1'b0);
         chk1("req_valid", mem_req_valid, 1'b1);
         chk("req_addr", mem_req_addr, waddr);
         chk1("req_we", mem_req_we, mw);
         if (mw) begin
            chk("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, m_wstrb(alu, f3)});
            chk("req_wdata", mem_req_wdata, m_wdata(rs2, f3));
         end
         garbage_ex();
         for (int i = 0; i < rdy_dly; i++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = rbit();
            mem_rsp_rdata = $urandom;
            tick();
            garbage_ex();
            chk1("hold_req_valid", mem_req_valid, 1'b1);
            chk("hold_req_addr", mem_req_addr, waddr);
            chk1("hold_stall", lsu_stall, 1'b1);
            if (mw) chk("hold_wstrb", {28'd0, mem_req_wstrb}, {28'd0, m_wstrb(alu, f3)});
         end
         mem_req_ready = 1'b1;
         mem_rsp_valid = 1'b0;
         tick();
         mem_req_ready = 1'b0;
         if (mw) begin
            ex_valid = 1'b0;
            chk1("st_wb_valid", wb_valid, 1'b1);
            chk1("st_wb_reg_write", wb_reg_write, 1'b0);
            chk1("st_stall", lsu_stall, 1'b0);
            chk1("st_req_valid", mem_req_valid, 1'b0);
         end else begin
            chk1("wait_stall", lsu_stall, 1'b1);
            chk1("wait_req_valid", mem_req_valid, 1'b0);
            chk1("wait_wb_valid", wb_valid, 1'b0);
            for (int i = 0; i < rsp_dly; i++) begin
               mem_req_ready = rbit();
               tick();
               garbage_ex();
               chk1("wait_hold_stall", lsu_stall, 1'b1);
               chk1("wait_hold_req_valid", mem_req_valid, 1'b0);
            end
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            tick();
            mem_rsp_valid = 1'b0;
            ex_valid      = 1'b0;
            chk1("ld_wb_valid", wb_valid, 1'b1);
            chk("ld_wb_data", wb_data, m_load(rdata, alu, f3));
            chk("ld_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
            chk1("ld_wb_reg_write", wb_reg_write, rw);
            chk1("ld_stall", lsu_stall, 1'b0);
         end
      end
      chk1("no_trap_after", (mr || mw) ? 1'b0 : misalign_trap, 1'b0);
      tick();
      chk1("wb_pulse_end", wb_valid, 1'b0);
      chk1("trap_pulse_end", misalign_trap, 1'b0);
`ifndef LSU_MISALIGN_TRAP_EN
      chk("misalign_addr_tied", misalign_addr, 32'h0);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_stall"}, lsu_stall, 1'b0);
      chk1({tag, "_req_valid"}, mem_req_valid, 1'b0);
      chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk1({tag, "_wb_reg_write"}, wb_reg_write, 1'b0);
      chk({tag, "_wb_data"}, wb_data, 32'h0);
      chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'h0);
      chk1({tag, "_trap"}, misalign_trap, 1'b0);
      chk({tag, "_trap_addr"}, misalign_addr, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic [1:0]  kind;
      rst_n         = 1'b0;
      ex_valid      = 1'b0;
      ex_alu_result = '0;
      ex_rs2_data   = '0;
      ex_funct3     = '0;
      ex_mem_read   = 1'b0;
      ex_mem_write  = 1'b0;
      ex_reg_write  = 1'b0;
      ex_rd         = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      tick();
      tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Directed scenarios
      run_op(32'h0000_1234, 32'h0, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
      run_op(32'h0000_0103, 32'hAABB_CCDD, 3'b000, 5'd4, 1'b0, 1'b0, 1'b1, 3, 0, 32'h0);
      chk("sb_wstrb_abs", {28'd0, m_wstrb(32'h103, 3'b000)}, 32'h8);
      run_op(32'h0000_0202, 32'h0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b0, 0, 1, 32'h0080_0000);
      run_op(32'h0000_0202, 32'h0, 3'b100, 5'd6, 1'b1, 1'b1, 1'b0, 0, 1, 32'h0080_0000);
      run_op(32'h0000_0302, 32'h0, 3'b001, 5'd7, 1'b1, 1'b1, 1'b0, 1, 0, 32'h8001_0000);
      run_op(32'h0000_0300, 32'h0, 3'b010, 5'd8, 1'b1, 1'b1, 1'b0, 0, 2, 32'hDEAD_BEEF);
      run_op(32'h0000_0401, 32'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 0, 0, 32'h1122_3344);
      run_op(32'h0000_0506, 32'h1234_5678, 3'b001, 5'd10, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0);
      run_op(32'h0000_0603, 32'h0, 3'b111, 5'd11, 1'b1, 1'b1, 1'b0, 0, 0, 32'hCAFE_F00D);

      // Reset while waiting for a load response
      ex_valid      = 1'b1;
      ex_alu_result = 32'h0000_0700;
      ex_funct3     = 3'b010;
      ex_mem_read   = 1'b1;
      ex_mem_write  = 1'b0;
      ex_reg_write  = 1'b1;
      ex_rd         = 5'd12;
      tick();
      ex_valid      = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk1("rst_pre_wait_stall", lsu_stall, 1'b1);
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("rst_mid");
      rst_n         = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'h5555_AAAA;
      tick();
      mem_rsp_valid = 1'b0;
      chk_reset_outputs("rst_late_rsp");
      tick();
      chk1("rst_late_rsp_wb2", wb_valid, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         a    = $urandom;
         d    = $urandom;
         f3   = 3'($urandom);
         kind = 2'($urandom_range(0, 2));
         run_op(a, d, f3, 5'($urandom), rbit(), kind == 2'd1, kind == 2'd2,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
